// File: rtl/operand_gen.sv
// Seedable 32-bit Galois-LFSR operand source: emits LOOPTOTAL (a, b) pairs per start
// over a valid/ready handshake and pulses o_done once the last pair is taken.
module operand_gen #(
  parameter int unsigned LOOPTOTAL = 10,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_seed_load,
  input  logic [31:0] i_seed,
  input  logic        i_ready,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(LOOPTOTAL - 1);

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  state_t      r_state;
  logic [31:0] r_lfsr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_count;

  logic [31:0] w_step1;
  logic [31:0] w_step2;
  logic        w_accept;
  logic        w_last;

  // Each pair consumes two LFSR steps: a = f(s), b = f(f(s)).
  assign w_step1  = lfsr_step(r_lfsr);
  assign w_step2  = lfsr_step(w_step1);
  assign w_accept = r_valid && i_ready;
  assign w_last   = (r_count == LAST_IDX);

  // Handshake FSM with all outputs registered; seed_load outranks start in IDLE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_lfsr  <= SEED;
      r_a     <= 32'h0000_0000;
      r_b     <= 32'h0000_0000;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_seed_load) begin
            r_lfsr <= (i_seed == 32'h0000_0000) ? SEED : i_seed;
          end else if (i_start) begin
            r_count <= 16'd0;
            r_a     <= w_step1;
            r_b     <= w_step2;
            r_lfsr  <= w_step2;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_count <= r_count + 16'd1;
            if (w_last) begin
              // a/b keep the last pair for inspection after the run
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_a    <= w_step1;
              r_b    <= w_step2;
              r_lfsr <= w_step2;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_count = r_count;

endmodule

// File: doc/operand_gen.md
# operand_gen

Synthesizable stimulus source that sits directly upstream of the 32-bit adder stage in the DPI add/compare environment. On a start command it produces LOOPTOTAL operand pairs (a, b) from a seedable 32-bit Galois LFSR. It presents each pair on a valid/ready handshake and pulses done after the last pair is accepted. It replaces testbench-side random generation with a cycle-accurate, reproducible RTL sequence that the C model can mirror bit-for-bit.

## Interface
- LOOPTOTAL, 10, pairs per run; legal range 1..65535
- SEED, 32'hACE1_2468, fallback seed used when a zero seed is loaded; must be non-zero

- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled in IDLE only
- seed_load  in  1  load seed into LFSR; sampled in IDLE only
- seed  in  32  seed value for seed_load
- ready  in  1  downstream accepts current pair
- a  out  32  operand A
- b  out  32  operand B
- valid  out  1  a/b hold a pair not yet accepted
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after last acceptance
- count  out  16  pairs accepted in current/last run

## Operation
- LFSR step function f(s) = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0), polynomial x^32+x^22+x^2+x+1.
- Each pair consumes two steps: a = f(s), b = f(f(s)), then s <= f(f(s)).
- Reset:
  - lfsr = SEED
  - state = IDLE
  - a = 0, b = 0
  - valid = 0, busy = 0, done = 0, count = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - seed_load=1 → lfsr <= (seed==0 ? SEED : seed).
  - start=1 → count <= 0, generate first pair into a/b, valid <= 1, go RUN.
  - If start and seed_load are both high, seed_load wins this cycle and start is ignored.
  - A pending pair is never lost.
- RUN:
  - valid stays high until valid&&ready.
  - On acceptance, count <= count+1.
  - If count == LOOPTOTAL-1: valid <= 0, go DONE; a/b hold the last pair.
  - Otherwise the next pair loads on the same edge, valid stays 1 (no bubble).
  - ready low: a, b, valid, lfsr, count all hold.
- DONE: done=1 for exactly one cycle, then IDLE.
- start and seed_load are ignored outside IDLE.
- busy = (state != IDLE), registered.
- The LFSR is not reseeded between runs; consecutive runs continue the sequence.
- The LFSR never reaches zero; no zero-state lockup handling beyond the seed fallback.

## Timing
- start in cycle N → valid=1 and first pair visible in cycle N+1.
- Back-to-back acceptance: one pair per cycle at full throughput.
- Last acceptance at edge M → valid=0 and done=1 in cycle M+1 → done=0 and busy=0 in cycle M+2 → start honoured from M+2.
- Minimum run length: LOOPTOTAL+2 cycles from start (start cycle, LOOPTOTAL transfers, DONE).
- reset mid-run wins over everything: next cycle matches reset values, and the pending pair is discarded.
- ready high while valid low has no effect.
- count holds its final value (LOOPTOTAL) until the next start.

## Test plan
- Reset check: reset for 2 cycles, then release.
  - Expect a=b=0, valid=busy=done=0, count=0.
  - Expect start before any seed_load to produce the pair derived from SEED.
- Seed 1, LOOPTOTAL=10, ready tied high: seed_load seed=32'h1, then start.
  - Pair 0: a=32'h8020_0003, b=32'hC030_0002.
  - Pair 1: a=32'h6018_0001, b=32'hB02C_0003.
  - 10 consecutive transfers, done pulses once, count=10.
- Backpressure: ready toggled pseudo-randomly.
  - a/b/valid stable while ready=0.
  - Pair sequence identical to the ready-high run.
  - Exactly 10 transfers.
- Zero seed: seed_load seed=0, then start.
  - Output sequence identical to the one after reset (SEED fallback).
- Ignored commands: pulse start and seed_load mid-RUN, and start+seed_load together in IDLE.
  - No restart and no reseed during RUN.
  - The simultaneous case reseeds only; busy stays 0.
- Reset mid-run: assert reset after 4 transfers.
  - Outputs return to reset values next cycle.
  - A new start yields the SEED-derived first pair, with count restarting at 0.
